// File: rtl/sd_spi_arbiter.sv
// Shares one SPI byte engine between a Z80 byte port and a DMA requester.
// Define SD_SPI_DMA_EN to enable the DMA requester; otherwise the Z80 owns every transfer.
module sd_spi_arbiter #(
  parameter int TMO_CYC = 255
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       z_start,
  input  logic [7:0] z_din,
  output logic [7:0] z_dout,
  output logic       z_busy,
  output logic       z_ovr,
  input  logic       z_ovr_clr,
  input  logic       dma_req,
  input  logic [7:0] dma_din,
  output logic       dma_ack,
  output logic [7:0] dma_dout,
  output logic       spi_start,
  output logic [7:0] spi_din,
  input  logic [7:0] spi_dout,
  input  logic       spi_rdy,
  output logic       spi_tmo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [7:0] TmoLast = 8'(TMO_CYC - 1);

  state_e     state_q;
  logic       z_pend_q;
  logic       z_ovr_q;
  logic       spi_tmo_q;
  logic       spi_start_q;
  logic [7:0] z_txbuf_q;
  logic [7:0] z_dout_q;
  logic [7:0] spi_din_q;
  logic [7:0] cnt_q;

  logic       owner_dma;
  logic       z_acc;
  logic       z_req;
  logic       gnt;
  logic       gnt_dma;
  logic       xfer_ok;
  logic       xfer_tmo;
  logic       xfer_end;
  logic [7:0] tx_d;
  logic [7:0] rx_d;

`ifdef SD_SPI_DMA_EN
  logic       owner_q;
  logic       last_dma_q;
  logic       dma_ack_q;
  logic [7:0] dma_dout_q;

  assign gnt_dma   = dma_req & (~z_req | ~last_dma_q);
  assign owner_dma = owner_q;
  assign dma_ack   = dma_ack_q;
  assign dma_dout  = dma_dout_q;
  assign tx_d      = gnt_dma ? dma_din
                   : (z_pend_q ? z_txbuf_q : z_din);
`else
  logic unused_dma;

  assign unused_dma = ^{dma_req, dma_din};
  assign gnt_dma    = 1'b0;
  assign owner_dma  = 1'b0;
  assign dma_ack    = 1'b0;
  assign dma_dout   = 8'hFF;
  assign tx_d       = z_pend_q ? z_txbuf_q : z_din;
`endif

  assign z_busy = z_pend_q
                | (((state_q == S_ISSUE) | (state_q == S_BUSY))
                   & ~owner_dma);
  assign z_acc  = z_start & ~z_busy;
  // A byte accepted this cycle already competes for the engine
  assign z_req  = z_pend_q | z_acc;
  assign gnt    = (state_q == S_IDLE) & spi_rdy & (z_req | gnt_dma);

  assign xfer_ok  = (state_q == S_BUSY) & (cnt_q != 8'd0) & spi_rdy;
  assign xfer_tmo = (state_q == S_BUSY) & ~xfer_ok
                  & (cnt_q == TmoLast);
  assign xfer_end = xfer_ok | xfer_tmo;
  assign rx_d     = xfer_tmo ? 8'hFF : spi_dout;

  assign z_dout    = z_dout_q;
  assign z_ovr     = z_ovr_q;
  assign spi_start = spi_start_q;
  assign spi_din   = spi_din_q;
  assign spi_tmo   = spi_tmo_q;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      z_pend_q    <= 1'b0;
      z_ovr_q     <= 1'b0;
      spi_tmo_q   <= 1'b0;
      spi_start_q <= 1'b0;
      z_txbuf_q   <= 8'hFF;
      z_dout_q    <= 8'hFF;
      spi_din_q   <= 8'hFF;
      cnt_q       <= 8'd0;
`ifdef SD_SPI_DMA_EN
      owner_q     <= 1'b0;
      last_dma_q  <= 1'b1;
      dma_ack_q   <= 1'b0;
      dma_dout_q  <= 8'hFF;
`endif
    end else begin
      spi_start_q <= 1'b0;
`ifdef SD_SPI_DMA_EN
      dma_ack_q   <= 1'b0;
`endif
      if (z_acc) begin
        z_txbuf_q <= z_din;
        z_pend_q  <= 1'b1;
      end
      if (z_start & z_busy) begin
        z_ovr_q <= 1'b1;
      end else if (z_ovr_clr) begin
        z_ovr_q <= 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (gnt) begin
            state_q     <= S_ISSUE;
            spi_start_q <= 1'b1;
            spi_din_q   <= tx_d;
`ifdef SD_SPI_DMA_EN
            owner_q     <= gnt_dma;
`endif
          end
        end
        S_ISSUE: begin
          if (!owner_dma) begin
            z_pend_q <= 1'b0;
          end
          cnt_q   <= 8'd0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          if (xfer_end) begin
            state_q <= S_DONE;
            if (xfer_tmo) begin
              spi_tmo_q <= 1'b1;
            end
`ifdef SD_SPI_DMA_EN
            if (owner_q) begin
              dma_dout_q <= rx_d;
              dma_ack_q  <= 1'b1;
            end else begin
              z_dout_q <= rx_d;
            end
`else
            z_dout_q <= rx_d;
`endif
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
`ifdef SD_SPI_DMA_EN
          last_dma_q <= owner_q;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
